// File: rtl/acc_en_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : acc_en_sched                                               |
// | Purpose  : Power-up scheduler for the clock/reset enables of up to    |
// |            NUM_ACC accelerator domains. Staggers grants, caps the     |
// |            number of live domains, arbitrates round-robin and holds   |
// |            each domain enabled until it drains to idle.               |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module acc_en_sched #(
   parameter int NUM_ACC      = 4,
   parameter int MAX_ACTIVE   = 2,
   parameter int STAGGER_CYC  = 16,
   parameter int RST_WAIT_CYC = 12
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic [NUM_ACC-1:0]           req_i,
   input  logic [NUM_ACC-1:0]           idle_i,
   output logic [NUM_ACC-1:0]           core_en_o,
   output logic [NUM_ACC-1:0]           ready_o,
   output logic [$clog2(NUM_ACC+1)-1:0] active_cnt_o,
   output logic                         busy_o
);

   // Counter widths cover only the largest loaded value; a load of 0
   // still needs one bit to hold it.
   localparam int c_CNT_W  = $clog2(NUM_ACC + 1);
   localparam int c_PTR_W  = (NUM_ACC > 1)      ? $clog2(NUM_ACC)      : 1;
   localparam int c_STAG_W = (STAGGER_CYC > 1)  ? $clog2(STAGGER_CYC)  : 1;
   localparam int c_WAIT_W = (RST_WAIT_CYC > 1) ? $clog2(RST_WAIT_CYC) : 1;

   localparam logic [c_STAG_W-1:0] c_STAG_LOAD = c_STAG_W'(STAGGER_CYC - 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(RST_WAIT_CYC - 1);
   localparam logic [c_CNT_W-1:0]  c_MAX_ACT   = c_CNT_W'(MAX_ACTIVE);
   localparam logic [c_PTR_W-1:0]  c_LAST_IDX  = c_PTR_W'(NUM_ACC - 1);

   typedef enum logic [1:0] {
      S_OFF   = 2'd0,
      S_PWRUP = 2'd1,
      S_ON    = 2'd2,
      S_DRAIN = 2'd3
   } dom_state_t;

   // Per-domain state and reset-release wait counters
   dom_state_t          r_state     [NUM_ACC];
   dom_state_t          w_state_nxt [NUM_ACC];
   logic [c_WAIT_W-1:0] r_wait      [NUM_ACC];
   logic [c_WAIT_W-1:0] w_wait_nxt  [NUM_ACC];

   // Shared scheduling state
   logic [c_STAG_W-1:0] r_stag;
   logic [c_STAG_W-1:0] w_stag_nxt;
   logic [c_PTR_W-1:0]  r_ptr;
   logic [c_PTR_W-1:0]  w_ptr_nxt;
   logic [c_CNT_W-1:0]  r_active_cnt;
   logic [c_CNT_W-1:0]  w_active_nxt;

   // Registered outputs and their next values
   logic [NUM_ACC-1:0]  r_core_en;
   logic [NUM_ACC-1:0]  r_ready;
   logic [NUM_ACC-1:0]  w_core_en_nxt;
   logic [NUM_ACC-1:0]  w_ready_nxt;

   // Arbitration
   logic [NUM_ACC-1:0]  w_elig;
   logic [NUM_ACC-1:0]  w_grant_vec;
   logic                w_found_hi;
   logic                w_found_lo;
   logic [c_PTR_W-1:0]  w_win_hi;
   logic [c_PTR_W-1:0]  w_win_lo;
   logic [c_PTR_W-1:0]  w_win;
   logic                w_grant;
   logic                w_busy;

   // A domain may be granted only from OFF and while it requests
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_ACC; i++) begin
         w_elig[i] = (r_state[i] == S_OFF) && req_i[i];
      end
   end

   // Round-robin pick: lowest eligible index at/above the pointer,
   // otherwise wrap around to the lowest eligible index overall
   always_comb begin
      w_found_hi = 1'b0;
      w_found_lo = 1'b0;
      w_win_hi   = '0;
      w_win_lo   = '0;
      // Descending scan so the last hit written is the lowest index
      for (int i = NUM_ACC - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_found_lo = 1'b1;
            w_win_lo   = c_PTR_W'(i);
            if (c_PTR_W'(i) >= r_ptr) begin
               w_found_hi = 1'b1;
               w_win_hi   = c_PTR_W'(i);
            end
         end
      end
      w_win = w_found_hi ? w_win_hi : w_win_lo;
   end

   // Grant gate: stagger expired, slot available (registered count, so a
   // slot freed this cycle is only reusable next cycle), someone waiting
   always_comb begin
      w_grant     = w_found_lo && (r_stag == '0) && (r_active_cnt < c_MAX_ACT);
      w_grant_vec = '0;
      for (int i = 0; i < NUM_ACC; i++) begin
         w_grant_vec[i] = w_grant && (w_win == c_PTR_W'(i));
      end
   end

   // Pointer advance and stagger counter (saturates at zero)
   always_comb begin
      w_ptr_nxt  = r_ptr;
      w_stag_nxt = r_stag;
      if (w_grant) begin
         w_ptr_nxt  = (w_win == c_LAST_IDX) ? '0 : (w_win + c_PTR_W'(1));
         w_stag_nxt = c_STAG_LOAD;
      end else if (r_stag != '0) begin
         w_stag_nxt = r_stag - c_STAG_W'(1);
      end
   end

   // Per-domain next state, next outputs and next live-domain count
   always_comb begin
      w_active_nxt  = '0;
      w_core_en_nxt = '0;
      w_ready_nxt   = '0;
      for (int i = 0; i < NUM_ACC; i++) begin
         w_state_nxt[i] = r_state[i];
         w_wait_nxt[i]  = r_wait[i];
         case (r_state[i])
            S_OFF: begin
               if (w_grant_vec[i]) begin
                  w_state_nxt[i] = S_PWRUP;
                  w_wait_nxt[i]  = c_WAIT_LOAD;
               end
            end
            S_PWRUP: begin
               // A dropped request beats wait expiry in the same cycle
               if (!req_i[i]) begin
                  w_state_nxt[i] = S_DRAIN;
               end else if (r_wait[i] == '0) begin
                  w_state_nxt[i] = S_ON;
               end else begin
                  w_wait_nxt[i] = r_wait[i] - c_WAIT_W'(1);
               end
            end
            S_ON: begin
               if (!req_i[i]) begin
                  w_state_nxt[i] = S_DRAIN;
               end
            end
            S_DRAIN: begin
               // Requests are ignored here; only idle lets the domain go
               if (idle_i[i]) begin
                  w_state_nxt[i] = S_OFF;
               end
            end
            default: begin
               w_state_nxt[i] = S_OFF;
            end
         endcase
         w_core_en_nxt[i] = (w_state_nxt[i] != S_OFF);
         w_ready_nxt[i]   = (w_state_nxt[i] == S_ON);
         if (w_state_nxt[i] != S_OFF) begin
            w_active_nxt = w_active_nxt + c_CNT_W'(1);
         end
      end
   end

   // State and output registers; reset drops every enable at once
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         for (int i = 0; i < NUM_ACC; i++) begin
            r_state[i] <= S_OFF;
            r_wait[i]  <= '0;
         end
         r_stag       <= '0;
         r_ptr        <= '0;
         r_active_cnt <= '0;
         r_core_en    <= '0;
         r_ready      <= '0;
      end else begin
         for (int i = 0; i < NUM_ACC; i++) begin
            r_state[i] <= w_state_nxt[i];
            r_wait[i]  <= w_wait_nxt[i];
         end
         r_stag       <= w_stag_nxt;
         r_ptr        <= w_ptr_nxt;
         r_active_cnt <= w_active_nxt;
         r_core_en    <= w_core_en_nxt;
         r_ready      <= w_ready_nxt;
      end
   end

   // Busy while any domain is in transition or the stagger is running
   always_comb begin
      w_busy = (r_stag != '0);
      for (int i = 0; i < NUM_ACC; i++) begin
         if ((r_state[i] == S_PWRUP) || (r_state[i] == S_DRAIN)) begin
            w_busy = 1'b1;
         end
      end
   end

   assign core_en_o    = r_core_en;
   assign ready_o      = r_ready;
   assign active_cnt_o = r_active_cnt;
   assign busy_o       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_acc_en_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_acc_en_sched                                            |
// | Purpose  : Directed self-checking bench for acc_en_sched with the     |
// |            default parameters (4 domains, 2 active, stagger 16,       |
// |            reset wait 12).                                            |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_acc_en_sched;

   logic       clk_i;
   logic       reset_n_i;
   logic [3:0] req_i;
   logic [3:0] idle_i;
   logic [3:0] core_en_o;
   logic [3:0] ready_o;
   logic [2:0] active_cnt_o;
   logic       busy_o;

   int n_assert;
   int n_fail;

   acc_en_sched #(
      .NUM_ACC      (4),
      .MAX_ACTIVE   (2),
      .STAGGER_CYC  (16),
      .RST_WAIT_CYC (12)
   ) u_dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .req_i        (req_i),
      .idle_i       (idle_i),
      .core_en_o    (core_en_o),
      .ready_o      (ready_o),
      .active_cnt_o (active_cnt_o),
      .busy_o       (busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Edge numbers Ek in comments count rising edges after the idle point E0
   initial begin
      n_assert  = 0;
      n_fail    = 0;
      reset_n_i = 1'b0;
      req_i     = 4'b0000;
      idle_i    = 4'b0000;
      tick(3);
      chk("rst_core_en", core_en_o, 4'b0000);
      chk("rst_ready", ready_o, 4'b0000);
      chk("rst_cnt", {1'b0, active_cnt_o}, 4'd0);
      chk("rst_busy", {3'b000, busy_o}, 4'd0);

      reset_n_i = 1'b1;
      tick(2);                                   // E0
      chk("idle_core_en", core_en_o, 4'b0000);

      // Single request: grant at E1, ready 12 edges later
      req_i = 4'b0001;
      tick(1);                                   // E1
      chk("single_core_en", core_en_o, 4'b0001);
      chk("single_ready_lo", ready_o, 4'b0000);
      chk("single_cnt", {1'b0, active_cnt_o}, 4'd1);
      chk("single_busy", {3'b000, busy_o}, 4'd1);
      tick(11);                                  // E12
      chk("single_ready_e12", ready_o, 4'b0000);
      tick(1);                                   // E13
      chk("single_ready_e13", ready_o, 4'b0001);
      tick(3);                                   // E16: stagger expired
      chk("single_busy_done", {3'b000, busy_o}, 4'd0);

      // All request: pointer at 1, one slot left -> domain 1 only
      req_i = 4'b1111;
      tick(1);                                   // E17
      chk("all_core_en", core_en_o, 4'b0011);
      chk("all_cnt", {1'b0, active_cnt_o}, 4'd2);
      tick(20);                                  // E37: cap holds 2 and 3
      chk("cap_core_en", core_en_o, 4'b0011);
      chk("cap_ready", ready_o, 4'b0011);
      chk("cap_cnt", {1'b0, active_cnt_o}, 4'd2);

      // Release domain 0 without idle: ready drops, enable stays
      req_i = 4'b1110;
      tick(1);                                   // E38
      chk("drain_ready", ready_o, 4'b0010);
      chk("drain_core_en", core_en_o, 4'b0011);
      tick(20);                                  // E58
      chk("drain_hold", core_en_o, 4'b0011);
      chk("drain_cnt", {1'b0, active_cnt_o}, 4'd2);
      idle_i = 4'b0001;
      tick(1);                                   // E59: domain 0 off
      chk("drain_off", core_en_o, 4'b0010);
      chk("drain_off_cnt", {1'b0, active_cnt_o}, 4'd1);
      tick(1);                                   // E60: freed slot -> domain 2
      chk("regrant_core_en", core_en_o, 4'b0110);
      chk("regrant_cnt", {1'b0, active_cnt_o}, 4'd2);
      idle_i = 4'b0000;

      // Abort domain 2 in PWRUP, sampled 5 cycles after its grant
      tick(4);                                   // E64
      req_i = 4'b1010;
      tick(1);                                   // E65
      chk("abort_core_en", core_en_o, 4'b0110);
      chk("abort_ready", ready_o, 4'b0010);
      tick(10);                                  // E75: past normal ready time
      chk("abort_no_ready", ready_o, 4'b0010);
      chk("abort_busy", {3'b000, busy_o}, 4'd1);
      idle_i = 4'b0100;
      tick(1);                                   // E76
      chk("abort_off", core_en_o, 4'b0010);
      chk("abort_off_cnt", {1'b0, active_cnt_o}, 4'd1);
      tick(1);                                   // E77: pointer 3 -> domain 3
      chk("grant3_core_en", core_en_o, 4'b1010);
      idle_i = 4'b0000;

      // Release everything; idle already high only counts once in DRAIN
      req_i  = 4'b0000;
      idle_i = 4'b1111;
      tick(1);                                   // E78
      chk("rel_core_en", core_en_o, 4'b1010);
      chk("rel_ready", ready_o, 4'b0000);
      tick(1);                                   // E79
      chk("rel_off", core_en_o, 4'b0000);
      chk("rel_cnt", {1'b0, active_cnt_o}, 4'd0);
      chk("rel_busy_stag", {3'b000, busy_o}, 4'd1);

      // Move pointer to 2 by granting domain 1 and dropping it again
      idle_i = 4'b0000;
      req_i  = 4'b0010;
      tick(14);                                  // E93
      chk("ptr_setup_grant", core_en_o, 4'b0010);
      req_i  = 4'b0000;
      idle_i = 4'b0010;
      tick(2);                                   // E95
      chk("ptr_setup_off", core_en_o, 4'b0000);

      // Round-robin: 1 and 3 waiting, pointer 2 -> 3 first, then 1
      idle_i = 4'b0000;
      req_i  = 4'b1010;
      tick(13);                                  // E108: stagger just expired
      chk("rr_wait", core_en_o, 4'b0000);
      chk("rr_busy_lo", {3'b000, busy_o}, 4'd0);
      tick(1);                                   // E109
      chk("rr_first", core_en_o, 4'b1000);
      tick(15);                                  // E124
      chk("rr_stagger", core_en_o, 4'b1000);
      tick(1);                                   // E125
      chk("rr_second", core_en_o, 4'b1010);
      chk("rr_cnt", {1'b0, active_cnt_o}, 4'd2);
      tick(12);                                  // E137: both ON, pointer 2
      chk("rr_ready", ready_o, 4'b1010);

      // Asynchronous reset with two domains ON
      reset_n_i = 1'b0;
      #1;
      chk("mid_rst_core_en", core_en_o, 4'b0000);
      chk("mid_rst_ready", ready_o, 4'b0000);
      chk("mid_rst_cnt", {1'b0, active_cnt_o}, 4'd0);
      chk("mid_rst_busy", {3'b000, busy_o}, 4'd0);
      tick(2);
      reset_n_i = 1'b1;
      tick(1);                                   // pointer restarts at 0
      chk("post_rst_grant", core_en_o, 4'b0010);
      chk("post_rst_cnt", {1'b0, active_cnt_o}, 4'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
